arctan_scheduler: RTL and testbench

Round-robin scheduler that shares one iterative CORDIC arctan core among `N_CH` requesters, such as per-antenna-pair phase channels in the unitary ESPRIT DOA chain. It accepts (y, x) pairs over per-channel valid/ready handshakes and issues one job at a time to the core. Each core result is returned tagged with the originating channel id. A watchdog recovers from a core that never answers.

---
 rtl/arctan_scheduler.sv | 137 +++++++++++++
 tb/tb_arctan_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arctan_scheduler.sv
// Round-robin front end sharing one iterative CORDIC arctan core among N_CH requesters.
// Results come back tagged with the requesting channel; a watchdog retires jobs the core never answers.
module arctan_scheduler #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DIN_WIDTH  = 16,
  parameter int unsigned DOUT_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0]               in_valid,
  output logic [N_CH-1:0]               in_ready,
  input  logic [N_CH*DIN_WIDTH-1:0]     in_y,
  input  logic [N_CH*DIN_WIDTH-1:0]     in_x,
  output logic [DIN_WIDTH-1:0]          core_y,
  output logic [DIN_WIDTH-1:0]          core_x,
  output logic                          core_din_valid,
  input  logic                          core_sys_ready,
  input  logic [DOUT_WIDTH-1:0]         core_dout,
  input  logic                          core_dout_valid,
  output logic [DOUT_WIDTH-1:0]         dout,
  output logic [$clog2(N_CH)-1:0]       dout_id,
  output logic                          dout_err,
  output logic                          dout_valid
);

  localparam int unsigned ID_W  = $clog2(N_CH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

  state_t               state, state_nx;
  logic [ID_W-1:0]      rr_ptr, id_reg, gnt_idx;
  logic                 gnt_found, xfer, timeout_hit;
  logic [CNT_W-1:0]     wait_cnt;
  logic [DIN_WIDTH-1:0] sel_y, sel_x;

  // Search for the first valid channel starting just after the last one served
  always_comb begin
    int j;
    j         = 0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 1; k <= int'(N_CH); k++) begin
      j = (int'(rr_ptr) + k) % int'(N_CH);
      if (!gnt_found && in_valid[ID_W'(j)]) begin
        gnt_idx   = ID_W'(j);
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (state == IDLE && core_sys_ready && gnt_found) in_ready[gnt_idx] = 1'b1;
  end

  assign xfer        = |(in_valid & in_ready);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    sel_y = '0;
    sel_x = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_y = in_y[i*DIN_WIDTH +: DIN_WIDTH];
        sel_x = in_x[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A result arriving on the timeout cycle takes precedence over the error
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (xfer) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (core_dout_valid)  state_nx = IDLE;
        else if (timeout_hit) state_nx = FLUSH;
      end
      FLUSH: if (core_sys_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= ID_W'(N_CH - 1);
      id_reg         <= '0;
      core_y         <= '0;
      core_x         <= '0;
      core_din_valid <= 1'b0;
      wait_cnt       <= '0;
      dout           <= '0;
      dout_id        <= '0;
      dout_err       <= 1'b0;
      dout_valid     <= 1'b0;
    end else begin
      core_din_valid <= 1'b0;
      dout_valid     <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            core_y         <= sel_y;
            core_x         <= sel_x;
            id_reg         <= gnt_idx;
            rr_ptr         <= gnt_idx;
            core_din_valid <= 1'b1;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (core_dout_valid) begin
            dout       <= core_dout;
            dout_id    <= id_reg;
            dout_err   <= 1'b0;
            dout_valid <= 1'b1;
          end else if (timeout_hit) begin
            dout       <= '0;
            dout_id    <= id_reg;
            dout_err   <= 1'b1;
            dout_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arctan_scheduler.sv
// Directed bench for arctan_scheduler with a latency-programmable stub core.
`timescale 1ns/1ps
module tb_arctan_scheduler;
  localparam int unsigned N_CH = 4, DW = 16, OW = 16, TMO = 64;

  logic                    clk = 1'b0, rst = 1'b1;
  logic [N_CH-1:0]         in_valid, in_ready;
  logic [N_CH*DW-1:0]      in_y = '0, in_x = '0;
  logic [DW-1:0]           core_y, core_x;
  logic                    core_din_valid, core_sys_ready;
  logic [OW-1:0]           core_dout = '0;
  logic                    core_dout_valid = 1'b0;
  logic [OW-1:0]           dout;
  logic [$clog2(N_CH)-1:0] dout_id;
  logic                    dout_err, dout_valid;

  always #5 clk = ~clk;

  arctan_scheduler #(.N_CH(N_CH), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_x(in_x),
    .core_y(core_y), .core_x(core_x), .core_din_valid(core_din_valid),
    .core_sys_ready(core_sys_ready), .core_dout(core_dout), .core_dout_valid(core_dout_valid),
    .dout(dout), .dout_id(dout_id), .dout_err(dout_err), .dout_valid(dout_valid));

  // Stub core: result appears 'stub_lat' cycles after the start pulse is sampled
  int          stub_lat = 18;
  logic [15:0] stub_val = 16'h2000;
  logic        stub_nr  = 1'b0;
  logic        stub_busy = 1'b0;
  int          stub_cnt = 0;
  assign core_sys_ready = !stub_busy && !stub_nr;
  always @(posedge clk) begin
    core_dout_valid <= 1'b0;
    if (core_din_valid) begin
      stub_busy <= 1'b1;
      stub_cnt  <= stub_lat;
    end else if (stub_busy) begin
      if (stub_cnt <= 1) begin
        stub_busy       <= 1'b0;
        core_dout_valid <= 1'b1;
        core_dout       <= stub_val;
      end else stub_cnt <= stub_cnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requests stay valid until the bench has seen them accepted
  int want[N_CH];
  int granted[N_CH];
  logic [N_CH-1:0] xfer = '0;
  always_comb begin
    in_valid = '0;
    for (int i = 0; i < int'(N_CH); i++) in_valid[i] = (want[i] > granted[i]);
  end

  int g_ch[$], g_cyc[$], i_cyc[$], i_y[$], i_x[$], d_val[$], d_id[$], d_err[$], d_cyc[$];
  int onehot_viol = 0;
  always @(negedge clk) begin
    xfer = rst ? '0 : (in_valid & in_ready);
    if ($countones(in_ready) > 1) onehot_viol++;
    for (int i = 0; i < int'(N_CH); i++)
      if (xfer[i]) begin g_ch.push_back(i); g_cyc.push_back(cyc); end
    if (core_din_valid) begin
      i_cyc.push_back(cyc);
      i_y.push_back(int'($signed(core_y)));
      i_x.push_back(int'($signed(core_x)));
    end
    if (dout_valid) begin
      d_val.push_back(int'(dout));
      d_id.push_back(int'(dout_id));
      d_err.push_back(int'(dout_err));
      d_cyc.push_back(cyc);
    end
  end
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < int'(N_CH); i++) granted[i] += int'(xfer[i]);
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic request(input int ch, input int y, input int x);
    in_y[ch*DW +: DW] = DW'(y);
    in_x[ch*DW +: DW] = DW'(x);
    want[ch] = granted[ch] + 1;
  endtask

  task automatic wait_grant(input int n);
    int k = 0;
    while (g_ch.size() < n && k < 400) begin tick(); k++; end
    if (g_ch.size() < n) chk("grant_wait", g_ch.size(), n);
  endtask

  task automatic wait_dout(input int n);
    int k = 0;
    while (d_val.size() < n && k < 400) begin tick(); k++; end
    if (d_val.size() < n) chk("dout_wait", d_val.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, db, ib, t, gb2, db2;
    repeat (3) tick();
    chk("rst_din_valid", int'(core_din_valid), 0);
    chk("rst_core_y", int'(core_y), 0);
    chk("rst_core_x", int'(core_x), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_id", int'(dout_id), 0);
    chk("rst_dout_err", int'(dout_err), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    tick();

    // Single request on channel 2
    gb = g_ch.size(); db = d_val.size(); ib = i_cyc.size();
    request(2, 100, 100);
    wait_grant(gb + 1);
    t = g_cyc[gb];
    chk("t1_grant_ch", g_ch[gb], 2);
    wait_dout(db + 1);
    chk("t1_issue_cyc", i_cyc[ib], t + 1);
    chk("t1_core_y", i_y[ib], 100);
    chk("t1_core_x", i_x[ib], 100);
    chk("t1_issue_cnt", i_cyc.size() - ib, 1);
    chk("t1_dout", d_val[db], 'h2000);
    chk("t1_dout_id", d_id[db], 2);
    chk("t1_dout_err", d_err[db], 0);
    chk("t1_dout_cyc", d_cyc[db], t + 21);

    // Round robin with all channels requesting from reset
    rst = 1'b1;
    stub_lat = 3;
    for (int i = 0; i < int'(N_CH); i++) want[i] = granted[i] + 100;
    tick(); tick();
    rst = 1'b0;
    gb = g_ch.size();
    wait_grant(gb + 6);
    for (int i = 0; i < int'(N_CH); i++) want[i] = granted[i];
    for (int k = 0; k < 6; k++) chk($sformatf("t2_order%0d", k), g_ch[gb + k], k % 4);
    repeat (20) tick();

    // Core not ready gates the grant
    stub_lat = 18;
    stub_nr = 1'b1;
    gb = g_ch.size(); db = d_val.size(); ib = i_cyc.size();
    request(1, 7, -3);
    repeat (5) begin
      tick();
      chk("t3_ready_low", int'(in_ready), 0);
    end
    chk("t3_no_grant", g_ch.size() - gb, 0);
    stub_nr = 1'b0;
    t = cyc;
    wait_grant(gb + 1);
    chk("t3_grant_cyc", g_cyc[gb], t);
    chk("t3_grant_ch", g_ch[gb], 1);
    wait_dout(db + 1);
    chk("t3_core_x", i_x[ib], -3);
    chk("t3_dout_id", d_id[db], 1);

    // Timeout, then a late core result that must be swallowed in FLUSH
    stub_lat = 70;
    gb = g_ch.size(); db = d_val.size();
    request(3, 5, 9);
    wait_grant(gb + 1);
    t = g_cyc[gb];
    wait_dout(db + 1);
    chk("t4_err_cyc", d_cyc[db], t + 66);
    chk("t4_err", d_err[db], 1);
    chk("t4_dout_zero", d_val[db], 0);
    chk("t4_dout_id", d_id[db], 3);
    stub_lat = 18;
    stub_val = 16'h0ABC;
    request(0, 1, 1);
    wait_grant(gb + 2);
    chk("t4_next_grant_cyc", g_cyc[gb + 1], t + 73);
    chk("t4_next_grant_ch", g_ch[gb + 1], 0);
    wait_dout(db + 2);
    chk("t4_next_id", d_id[db + 1], 0);
    chk("t4_next_err", d_err[db + 1], 0);
    chk("t4_next_dout", d_val[db + 1], 'h0ABC);
    chk("t4_next_cyc", d_cyc[db + 1], t + 94);

    // Result on the last WAIT cycle beats the timeout
    stub_lat = 63;
    stub_val = 16'h1234;
    gb = g_ch.size(); db = d_val.size();
    request(1, 2, 3);
    wait_grant(gb + 1);
    t = g_cyc[gb];
    wait_dout(db + 1);
    chk("t5_cyc", d_cyc[db], t + 66);
    chk("t5_err", d_err[db], 0);
    chk("t5_dout", d_val[db], 'h1234);
    chk("t5_id", d_id[db], 1);
    repeat (3) tick();

    // Reset during WAIT: stale result dropped, channel 0 served first afterwards
    stub_lat = 18;
    stub_val = 16'h0777;
    gb = g_ch.size(); db = d_val.size();
    request(2, 4, 4);
    wait_grant(gb + 1);
    t = g_cyc[gb];
    while (cyc < t + 4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gb2 = g_ch.size(); db2 = d_val.size();
    request(0, 11, 12);
    request(3, 13, 14);
    wait_grant(gb2 + 1);
    chk("t6_first_ch", g_ch[gb2], 0);
    chk("t6_first_cyc", g_cyc[gb2], t + 20);
    wait_dout(db2 + 1);
    chk("t6_first_id", d_id[db2], 0);
    chk("t6_first_err", d_err[db2], 0);
    chk("t6_first_dout_cyc", d_cyc[db2], t + 41);
    wait_grant(gb2 + 2);
    chk("t6_second_ch", g_ch[gb2 + 1], 3);
    wait_dout(db2 + 2);
    repeat (5) tick();
    chk("t6_dout_count", d_val.size() - db, 2);

    chk("onehot_in_ready", onehot_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
